fsm_event_logger: RTL and testbench

//  Downstream consumer of the maintenance FSM. Watches its current_state/reg_state

---
 rtl/fsm_event_logger.sv | 213 +++++++++++++++++++++
 tb/tb_fsm_event_logger.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_event_logger.sv
// fsm_event_logger: watches the maintenance FSM state outputs, logs every state
// transition with a timestamp into a show-ahead FIFO, counts entries into the
// error state and drives a registered alarm.
module fsm_event_logger #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TS_W      = 16,
    parameter logic [1:0]  ERR_STATE = 2'd2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               current_state,
    input  logic [7:0]               reg_state,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TS_W+11:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               err_count,
    output logic                     alarm
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = TS_W + 12;

    typedef enum logic [0:0] {StResetIdle, StRun} state_e;

    // Control FSM
    state_e state_q, state_d;
    logic   primed;

    // Event detection and timestamp
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [1:0]        prev_q, prev_d;
    logic              evt;
    logic              evt_err;
    logic [EntryW-1:0] evt_payload;

    // FIFO storage and bookkeeping
    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // Status
    logic              overflow_q, overflow_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              alarm_q, alarm_d;

    // ------------------------------------------------------------------------
    // FSM: RESET_IDLE until the first non-reset edge, then RUN until reset.
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StResetIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave idle on the first non-reset edge and never go back
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StResetIdle: state_d = StRun;
            StRun:       state_d = StRun;
            default:     state_d = StResetIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        primed = 1'b0;
        unique case (state_q)
            StResetIdle: primed = 1'b0;
            StRun:       primed = 1'b1;
            default:     primed = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------------

    // Transition detect and payload assembly; payload carries the pre-increment ts
    always_comb begin
        evt         = primed && (current_state != prev_q);
        evt_err     = evt && (current_state == ERR_STATE);
        evt_payload = {ts_q, prev_q, current_state, reg_state};
    end

    // Timestamp and previous-state next values; prev tracks the input on every edge
    // (on the priming edge this captures the initial state without logging it)
    always_comb begin
        ts_d   = ts_q + TS_W'(1);
        prev_d = current_state;
    end

    // Timestamp and previous-state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q   <= '0;
            prev_q <= '0;
        end else begin
            ts_q   <= ts_d;
            prev_q <= prev_d;
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------------

    // Push/pop arbitration; a simultaneous pop frees the slot a full push needs
    always_comb begin
        fifo_full  = (count_q == CntW'(DEPTH));
        fifo_empty = (count_q == '0);
        pop        = rd_en && !fifo_empty;
        wr_en      = evt && (!fifo_full || pop);
        drop       = evt && fifo_full && !pop;
    end

    // Pointer and occupancy next values; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_ptr_q] <= evt_payload;
        end
    end

    // ------------------------------------------------------------------------
    // Status: sticky overflow, saturating error counter, alarm
    // ------------------------------------------------------------------------

    // Status next values; err_count counts regardless of whether the entry was dropped
    always_comb begin
        overflow_d  = overflow_q | drop;
        err_count_d = err_count_q;
        if (evt_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        alarm_d     = (current_state == ERR_STATE);
    end

    // Status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            err_count_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
            alarm_q     <= alarm_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers only
    // ------------------------------------------------------------------------

    // Output drive; head entry shown ahead, zero while empty
    always_comb begin
        rd_valid  = !fifo_empty;
        rd_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
        full      = fifo_full;
        empty     = fifo_empty;
        overflow  = overflow_q;
        err_count = err_count_q;
        alarm     = alarm_q;
    end

endmodule

// File: tb/tb_fsm_event_logger.sv
// Directed testbench for fsm_event_logger: linear stimulus, immediate assertions.
module tb_fsm_event_logger;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  current_state;
    logic [7:0]  reg_state;
    logic        rd_en;
    logic        rd_valid;
    logic [27:0] rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  err_count;
    logic        alarm;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Scoreboard state
    logic [15:0] exp_ts;
    logic [1:0]  exp_prev;
    logic        exp_primed;
    logic [27:0] exp_q[$];

    fsm_event_logger #(
        .DEPTH    (DEPTH),
        .TS_W     (TS_W),
        .ERR_STATE(2'd2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .current_state(current_state),
        .reg_state    (reg_state),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .err_count    (err_count),
        .alarm        (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, updating the expected FIFO contents from the driven inputs
    task automatic tick();
        logic [27:0] p;
        bit          do_pop;
        bit          ev;
        p = {exp_ts, exp_prev, current_state, reg_state};
        if (!rst) begin
            exp_ts     = '0;
            exp_prev   = '0;
            exp_primed = 1'b0;
            exp_q.delete();
        end else begin
            do_pop = rd_en && (exp_q.size() != 0);
            ev     = exp_primed && (current_state != exp_prev);
            if (do_pop) void'(exp_q.pop_front());
            if (ev && (exp_q.size() < DEPTH)) exp_q.push_back(p);
            exp_prev   = current_state;
            exp_primed = 1'b1;
            exp_ts     = exp_ts + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag);
        logic [27:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 28'd0;
        check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
        check({tag, "_data"}, 64'(rd_data), 64'(e));
    endtask

    initial begin
        logic [15:0] last_ts;
        exp_ts     = '0;
        exp_prev   = '0;
        exp_primed = 1'b0;
        rst           = 1'b0;
        current_state = 2'd1;
        reg_state     = 8'h00;
        rd_en         = 1'b0;

        // 1. Reset and priming
        tick();
        tick();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_alarm", 64'(alarm), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_rdvalid", 64'(rd_valid), 64'd0);
        check("rst_rddata", 64'(rd_data), 64'd0);
        rst = 1'b1;
        tick();
        check("prime_count", 64'(count), 64'd0);

        // 2. Single events, pop, timestamp value
        current_state = 2'd0;
        reg_state     = 8'h05;
        tick();
        check("ev1_count", 64'(count), 64'd1);
        check("ev1_data", 64'(rd_data), 64'({16'd1, 2'd1, 2'd0, 8'h05}));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ev1_pop_empty", 64'(empty), 64'd1);
        repeat (4) tick();
        current_state = 2'd1;
        tick();
        check("ev7_count", 64'(count), 64'd1);
        check("ev7_valid", 64'(rd_valid), 64'd1);
        check("ev7_data", 64'(rd_data), 64'({16'd7, 2'd0, 2'd1, 8'h05}));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ev7_pop_empty", 64'(empty), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("underflow_empty", 64'(empty), 64'd1);
        check("underflow_count", 64'(count), 64'd0);

        // 3. Error state entry and alarm
        current_state = 2'd2;
        tick();
        check("err_cnt1", 64'(err_count), 64'd1);
        check("err_alarm1", 64'(alarm), 64'd1);
        check("err_count_fifo", 64'(count), 64'd1);
        repeat (3) tick();
        check("err_hold_count", 64'(count), 64'd1);
        check("err_hold_alarm", 64'(alarm), 64'd1);
        current_state = 2'd0;
        tick();
        check("err_exit_alarm", 64'(alarm), 64'd0);
        check("err_exit_cnt", 64'(err_count), 64'd1);
        check_head("err_head");
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        check("err_drain_empty", 64'(empty), 64'd1);

        // 4. Overflow: 9 transitions, no reads
        for (int i = 0; i < 9; i++) begin
            current_state = (current_state == 2'd0) ? 2'd1 : 2'd0;
            reg_state     = 8'h10 + 8'(i);
            tick();
        end
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        last_ts = '0;
        for (int i = 0; i < 8; i++) begin
            check_head("ovf_drain");
            check("ovf_drain_reg", 64'(rd_data[7:0]), 64'(8'h10 + 8'(i)));
            check("ovf_ts_order", 64'(rd_data[27:12] > last_ts), 64'd1);
            last_ts = rd_data[27:12];
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check("ovf_drained", 64'(empty), 64'd1);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // 5. Full FIFO with simultaneous push and pop
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t5_ovf_clear", 64'(overflow), 64'd0);
        check("t5_count0", 64'(count), 64'd0);
        for (int i = 0; i < 8; i++) begin
            current_state = (current_state == 2'd0) ? 2'd1 : 2'd0;
            reg_state     = 8'h20 + 8'(i);
            tick();
        end
        check("t5_full", 64'(full), 64'd1);
        check("t5_count8", 64'(count), 64'd8);
        current_state = (current_state == 2'd0) ? 2'd1 : 2'd0;
        reg_state     = 8'h30;
        rd_en         = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t5_pp_count", 64'(count), 64'd8);
        check("t5_pp_ovf", 64'(overflow), 64'd0);
        check("t5_head_reg", 64'(rd_data[7:0]), 64'h21);
        for (int i = 0; i < 8; i++) begin
            check_head("t5_drain");
            if (i == 7) check("t5_tail_reg", 64'(rd_data[7:0]), 64'h30);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check("t5_drained", 64'(empty), 64'd1);

        // 6. Error counter saturation, then reset mid-stream
        rd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            current_state = 2'd2;
            tick();
            if (i == 0) check("sat_first", 64'(err_count), 64'd1);
            if (i == 254) check("sat_255", 64'(err_count), 64'd255);
            current_state = 2'd0;
            tick();
        end
        check("sat_hold", 64'(err_count), 64'd255);
        tick();
        rd_en = 1'b0;
        check("sat_drained", 64'(empty), 64'd1);
        current_state = 2'd1;
        tick();
        current_state = 2'd0;
        tick();
        current_state = 2'd1;
        tick();
        check("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b0;
        tick();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_full", 64'(full), 64'd0);
        check("mid_rst_valid", 64'(rd_valid), 64'd0);
        check("mid_rst_data", 64'(rd_data), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        check("mid_rst_alarm", 64'(alarm), 64'd0);
        rst           = 1'b1;
        current_state = 2'd2;
        reg_state     = 8'hA5;
        tick();
        check("reprime_count", 64'(count), 64'd0);
        check("reprime_alarm", 64'(alarm), 64'd1);
        check("reprime_err", 64'(err_count), 64'd0);
        tick();
        check("reprime_hold", 64'(count), 64'd0);
        current_state = 2'd1;
        tick();
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_data", 64'(rd_data), 64'({16'd2, 2'd2, 2'd1, 8'hA5}));
        check("post_rst_err", 64'(err_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
